// File: rtl/seq_pkg.sv
// Shared types and limits for the sequence checker and its helpers.
package seq_pkg;

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} chk_state_t;

  localparam int LOCK_CNT_MIN = 2;

endpackage

// File: rtl/seq_sat_counter.sv
// Up-counter that sticks at all-ones and clears only on reset.
module seq_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/sequence_checker.sv
// Locks onto an arithmetic progression (next = prev + step mod 2^WIDTH)
// and flags every deviation seen while locked.
module sequence_checker
  import seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] step,
  output logic             locked,
  output logic             mismatch,
  output logic [WIDTH-1:0] expected,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CNT);

  chk_state_t       state_reg, state_next;
  logic [WIDTH-1:0] expected_reg, expected_next;
  logic [WIDTH-1:0] step_q_reg, step_q_next;
  logic [RUN_W-1:0] run_reg, run_next;
  logic             mismatch_reg, mismatch_next;

  logic             accept;
  logic             hit;
  logic             err_inc;
  logic [WIDTH-1:0] seed_value;
  logic [RUN_W-1:0] run_inc;

  assign accept     = en & in_valid;
  assign hit        = (in_data == expected_reg);
  assign seed_value = in_data + step;
  assign run_inc    = run_reg + RUN_W'(1);

  always_comb begin
    state_next    = state_reg;
    expected_next = expected_reg;
    step_q_next   = step_q_reg;
    run_next      = run_reg;
    mismatch_next = 1'b0;
    err_inc       = 1'b0;

    if (!en) begin
      // Disabling only abandons the run; prediction and counters are kept.
      state_next = IDLE;
      run_next   = '0;
    end else if (in_valid) begin
      case (state_reg)
        IDLE: begin
          expected_next = seed_value;
          step_q_next   = step;
          run_next      = RUN_W'(1);
          state_next    = ACQ;
        end
        ACQ: begin
          if (hit) begin
            expected_next = expected_reg + step_q_reg;
            run_next      = run_inc;
            if (run_inc == LOCK_RUN) state_next = LOCKED;
          end else begin
            expected_next = seed_value;
            step_q_next   = step;
            run_next      = RUN_W'(1);
          end
        end
        LOCKED: begin
          if (hit) begin
            expected_next = expected_reg + step_q_reg;
          end else begin
            mismatch_next = 1'b1;
            err_inc       = 1'b1;
            expected_next = seed_value;
            step_q_next   = step;
            run_next      = RUN_W'(1);
            state_next    = ACQ;
          end
        end
        default: begin
          state_next = IDLE;
          run_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      expected_reg <= '0;
      step_q_reg   <= '0;
      run_reg      <= '0;
      mismatch_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      expected_reg <= expected_next;
      step_q_reg   <= step_q_next;
      run_reg      <= run_next;
      mismatch_reg <= mismatch_next;
    end
  end

  // A lock threshold below two would make a single sample "consistent".
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (LOCK_CNT >= LOCK_CNT_MIN)
        else $error("sequence_checker: LOCK_CNT below LOCK_CNT_MIN");
    end
  end

  seq_sat_counter #(.W(CNT_W)) u_sample_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (accept),
    .count (sample_count)
  );

  seq_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .count (err_count)
  );

  assign locked   = (state_reg == LOCKED);
  assign mismatch = mismatch_reg;
  assign expected = expected_reg;

endmodule

// File: tb/tb_sequence_checker.sv
// Scenario bench for sequence_checker: a 16-bit counter instance and a
// 2-bit counter instance share stimulus; expectations flow through a queue.
module tb_sequence_checker;

  typedef struct packed {
    logic        lk;
    logic        mm;
    logic [7:0]  ex;
    logic [15:0] sc;
    logic [15:0] ec;
  } exp_t;

  typedef struct packed {
    logic       en;
    logic       v;
    logic [7:0] d;
    logic [7:0] st;
    exp_t       e;
  } row_t;

  logic        clk;
  logic        reset;
  logic        en;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [7:0]  step;

  logic        locked1, mismatch1;
  logic [7:0]  expected1;
  logic [15:0] sample_count1, err_count1;

  logic        locked2, mismatch2;
  logic [7:0]  expected2;
  logic [1:0]  sample_count2, err_count2;

  exp_t obs1, obs2;
  exp_t sb_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  sequence_checker #(.WIDTH(8), .LOCK_CNT(4), .CNT_W(16)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .step         (step),
    .locked       (locked1),
    .mismatch     (mismatch1),
    .expected     (expected1),
    .sample_count (sample_count1),
    .err_count    (err_count1)
  );

  sequence_checker #(.WIDTH(8), .LOCK_CNT(4), .CNT_W(2)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .step         (step),
    .locked       (locked2),
    .mismatch     (mismatch2),
    .expected     (expected2),
    .sample_count (sample_count2),
    .err_count    (err_count2)
  );

  assign obs1 = {locked1, mismatch1, expected1, sample_count1, err_count1};
  assign obs2 = {locked2, mismatch2, expected2, 14'd0, sample_count2, 14'd0, err_count2};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic row_t mk(input logic e, input logic v, input logic [7:0] d,
                              input logic [7:0] st, input logic lk, input logic mm,
                              input logic [7:0] ex, input logic [15:0] sc,
                              input logic [15:0] ec);
    row_t r;
    r.en   = e;
    r.v    = v;
    r.d    = d;
    r.st   = st;
    r.e.lk = lk;
    r.e.mm = mm;
    r.e.ex = ex;
    r.e.sc = sc;
    r.e.ec = ec;
    return r;
  endfunction

  // Drives one cycle of stimulus and queues what the DUT must show after it.
  task automatic apply(input row_t r);
    en       = r.en;
    in_valid = r.v;
    in_data  = r.d;
    step     = r.st;
    sb_q.push_back(r.e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t want;
    reset = 1'b1;
    apply(mk(1, 1, 8'd77, 8'd3, 0, 0, 0, 0, 0));
    want = sb_q.pop_front();
    n_cmp++;
    if (obs1 !== want) begin
      n_fail++;
      $display("FAIL reset_dut1: got %h want %h", obs1, want);
    end
    n_cmp++;
    if (obs2 !== want) begin
      n_fail++;
      $display("FAIL reset_dut2: got %h want %h", obs2, want);
    end
    reset = 1'b0;
    rows.push_back(mk(0, 0, 8'd0,  8'd3, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 8'd0,  8'd3, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 8'd55, 8'd3, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 8'd58, 8'd3, 0, 0, 0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      want = sb_q.pop_front();
      n_cmp++;
      if (obs1 !== want) begin
        n_fail++;
        $display("FAIL idle[%0d]: got lk=%0b mm=%0b ex=%0d sc=%0d ec=%0d want lk=%0b mm=%0b ex=%0d sc=%0d ec=%0d",
                 i, obs1.lk, obs1.mm, obs1.ex, obs1.sc, obs1.ec, want.lk, want.mm, want.ex, want.sc, want.ec);
      end
    end
  endtask

  task automatic test_lock();
    row_t rows[$];
    exp_t want;
    rows.push_back(mk(1, 1, 8'd10, 8'd3, 0, 0, 8'd13, 1, 0));
    rows.push_back(mk(1, 1, 8'd13, 8'd3, 0, 0, 8'd16, 2, 0));
    rows.push_back(mk(1, 1, 8'd16, 8'd3, 0, 0, 8'd19, 3, 0));
    rows.push_back(mk(1, 1, 8'd19, 8'd3, 1, 0, 8'd22, 4, 0));
    rows.push_back(mk(1, 0, 8'd99, 8'd3, 1, 0, 8'd22, 4, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      want = sb_q.pop_front();
      n_cmp++;
      if (obs1 !== want) begin
        n_fail++;
        $display("FAIL lock[%0d]: got lk=%0b mm=%0b ex=%0d sc=%0d ec=%0d want lk=%0b mm=%0b ex=%0d sc=%0d ec=%0d",
                 i, obs1.lk, obs1.mm, obs1.ex, obs1.sc, obs1.ec, want.lk, want.mm, want.ex, want.sc, want.ec);
      end
    end
  endtask

  task automatic test_mismatch();
    row_t rows[$];
    exp_t want;
    rows.push_back(mk(1, 1, 8'd22, 8'd3, 1, 0, 8'd25, 5, 0));
    rows.push_back(mk(1, 1, 8'd50, 8'd3, 0, 1, 8'd53, 6, 1));
    // step changes mid-run must not alter the captured increment
    rows.push_back(mk(1, 1, 8'd53, 8'd7, 0, 0, 8'd56, 7, 1));
    rows.push_back(mk(1, 1, 8'd56, 8'd7, 0, 0, 8'd59, 8, 1));
    rows.push_back(mk(1, 1, 8'd59, 8'd7, 1, 0, 8'd62, 9, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      want = sb_q.pop_front();
      n_cmp++;
      if (obs1 !== want) begin
        n_fail++;
        $display("FAIL mismatch[%0d]: got lk=%0b mm=%0b ex=%0d sc=%0d ec=%0d want lk=%0b mm=%0b ex=%0d sc=%0d ec=%0d",
                 i, obs1.lk, obs1.mm, obs1.ex, obs1.sc, obs1.ec, want.lk, want.mm, want.ex, want.sc, want.ec);
      end
    end
  endtask

  task automatic test_wrap();
    row_t rows[$];
    exp_t want;
    rows.push_back(mk(0, 0, 8'd0,   8'd3, 0, 0, 8'd62,  9, 1));
    rows.push_back(mk(1, 1, 8'd250, 8'd3, 0, 0, 8'd253, 10, 1));
    rows.push_back(mk(1, 1, 8'd253, 8'd3, 0, 0, 8'd0,   11, 1));
    rows.push_back(mk(1, 1, 8'd0,   8'd3, 0, 0, 8'd3,   12, 1));
    rows.push_back(mk(1, 1, 8'd3,   8'd3, 1, 0, 8'd6,   13, 1));
    rows.push_back(mk(0, 0, 8'd0,   8'd3, 0, 0, 8'd6,   13, 1));
    rows.push_back(mk(1, 1, 8'd1,   8'd3, 0, 0, 8'd4,   14, 1));
    rows.push_back(mk(1, 1, 8'd7,   8'd3, 0, 0, 8'd10,  15, 1));
    rows.push_back(mk(1, 1, 8'd9,   8'd3, 0, 0, 8'd12,  16, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      want = sb_q.pop_front();
      n_cmp++;
      if (obs1 !== want) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got lk=%0b mm=%0b ex=%0d sc=%0d ec=%0d want lk=%0b mm=%0b ex=%0d sc=%0d ec=%0d",
                 i, obs1.lk, obs1.mm, obs1.ex, obs1.sc, obs1.ec, want.lk, want.mm, want.ex, want.sc, want.ec);
      end
    end
  endtask

  task automatic test_enable();
    row_t rows[$];
    exp_t want;
    rows.push_back(mk(1, 1, 8'd12,  8'd3, 0, 0, 8'd15,  17, 1));
    rows.push_back(mk(1, 1, 8'd15,  8'd3, 0, 0, 8'd18,  18, 1));
    rows.push_back(mk(1, 1, 8'd18,  8'd3, 1, 0, 8'd21,  19, 1));
    rows.push_back(mk(0, 1, 8'd21,  8'd3, 0, 0, 8'd21,  19, 1));
    rows.push_back(mk(0, 1, 8'd90,  8'd3, 0, 0, 8'd21,  19, 1));
    rows.push_back(mk(1, 1, 8'd100, 8'd3, 0, 0, 8'd103, 20, 1));
    rows.push_back(mk(1, 1, 8'd103, 8'd3, 0, 0, 8'd106, 21, 1));
    rows.push_back(mk(1, 1, 8'd106, 8'd3, 0, 0, 8'd109, 22, 1));
    rows.push_back(mk(1, 1, 8'd109, 8'd3, 1, 0, 8'd112, 23, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      want = sb_q.pop_front();
      n_cmp++;
      if (obs1 !== want) begin
        n_fail++;
        $display("FAIL enable[%0d]: got lk=%0b mm=%0b ex=%0d sc=%0d ec=%0d want lk=%0b mm=%0b ex=%0d sc=%0d ec=%0d",
                 i, obs1.lk, obs1.mm, obs1.ex, obs1.sc, obs1.ec, want.lk, want.mm, want.ex, want.sc, want.ec);
      end
    end
  endtask

  // Exercises the 2-bit-counter instance: saturation, then reset mid-run.
  task automatic test_saturate();
    row_t rows[$];
    exp_t want;
    logic [7:0] ev;
    logic [7:0] bad;
    int ec;
    reset = 1'b1;
    rows.push_back(mk(1, 1, 8'd5, 8'd3, 0, 0, 0, 0, 0));
    apply(rows[0]);
    want = sb_q.pop_front();
    n_cmp++;
    if (obs2 !== want) begin
      n_fail++;
      $display("FAIL sat_reset: got %h want %h", obs2, want);
    end
    reset = 1'b0;
    rows.delete();
    rows.push_back(mk(1, 1, 8'd10, 8'd3, 0, 0, 8'd13, 1, 0));
    rows.push_back(mk(1, 1, 8'd13, 8'd3, 0, 0, 8'd16, 2, 0));
    rows.push_back(mk(1, 1, 8'd16, 8'd3, 0, 0, 8'd19, 3, 0));
    rows.push_back(mk(1, 1, 8'd19, 8'd3, 1, 0, 8'd22, 3, 0));
    ev = 8'd22;
    for (int k = 0; k < 5; k++) begin
      bad = ev + 8'd100;
      ec  = (k + 1 > 3) ? 3 : k + 1;
      rows.push_back(mk(1, 1, bad,          8'd3, 0, 1, bad + 8'd3,  3, 16'(ec)));
      rows.push_back(mk(1, 1, bad + 8'd3,   8'd3, 0, 0, bad + 8'd6,  3, 16'(ec)));
      rows.push_back(mk(1, 1, bad + 8'd6,   8'd3, 0, 0, bad + 8'd9,  3, 16'(ec)));
      rows.push_back(mk(1, 1, bad + 8'd9,   8'd3, 1, 0, bad + 8'd12, 3, 16'(ec)));
      ev = bad + 8'd12;
    end
    rows.push_back(mk(0, 0, 8'd0,  8'd3, 0, 0, ev,    3, 3));
    rows.push_back(mk(1, 1, 8'd40, 8'd3, 0, 0, 8'd43, 3, 3));
    rows.push_back(mk(1, 1, 8'd43, 8'd3, 0, 0, 8'd46, 3, 3));
    foreach (rows[i]) begin
      apply(rows[i]);
      want = sb_q.pop_front();
      n_cmp++;
      if (obs2 !== want) begin
        n_fail++;
        $display("FAIL saturate[%0d]: got lk=%0b mm=%0b ex=%0d sc=%0d ec=%0d want lk=%0b mm=%0b ex=%0d sc=%0d ec=%0d",
                 i, obs2.lk, obs2.mm, obs2.ex, obs2.sc, obs2.ec, want.lk, want.mm, want.ex, want.sc, want.ec);
      end
    end
    reset = 1'b1;
    apply(mk(1, 1, 8'd46, 8'd3, 0, 0, 0, 0, 0));
    want = sb_q.pop_front();
    n_cmp++;
    if (obs2 !== want) begin
      n_fail++;
      $display("FAIL midrun_reset: got %h want %h", obs2, want);
    end
    reset = 1'b0;
    apply(mk(1, 1, 8'd77, 8'd3, 0, 0, 8'd80, 1, 0));
    want = sb_q.pop_front();
    n_cmp++;
    if (obs2 !== want) begin
      n_fail++;
      $display("FAIL post_reset_seed: got %h want %h", obs2, want);
    end
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    step     = 8'd3;
    test_reset();
    test_lock();
    test_mismatch();
    test_wrap();
    test_enable();
    test_saturate();
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sequence_checker.md
# sequence_checker

Receive-side counterpart of `sequence_generator`: consumes the generated value stream and checks that it follows an arithmetic progression, next = previous + `step`, mod 2^WIDTH. The checker acquires lock after a run of consistent samples, then flags every deviation. It maintains saturating sample and error counters. It sits on the same `sequence_intf` stream, downstream of the generator, in both the DUT environment and the scoreboard path.

## Interface
- `WIDTH`, default 8: data and step width.
- `LOCK_CNT`, default 4: consecutive consistent samples needed to lock. The first sample of a run counts. Legal values are ≥ 2.
- `CNT_W`, default 16: width of the sample and error counters.

- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  checking enable; low forces IDLE.
- `in_valid`  in  1  sample qualifier, one sample per cycle.
- `in_data`  in  WIDTH  sample value.
- `step`  in  WIDTH  progression increment; captured on the first sample of each run.
- `locked`  out  1  high while in LOCKED.
- `mismatch`  out  1  one-cycle pulse on a deviation while LOCKED.
- `expected`  out  WIDTH  predicted value of the next sample.
- `sample_count`  out  CNT_W  accepted samples, saturating.
- `err_count`  out  CNT_W  mismatches while LOCKED, saturating.

## Operation
- A sample is accepted when `en & in_valid`. When `en` is 0, `in_valid` is ignored.
- States: IDLE, ACQ, LOCKED. Internal registers: `step_q`, `run` (width `$clog2(LOCK_CNT+1)`).
- **IDLE**, on an accepted sample:
  - seed: `expected <= in_data + step`, `step_q <= step`, `run <= 1`;
  - go to ACQ.
- **ACQ**, on an accepted sample:
  - Match (`in_data == expected`): `expected += step_q`, `run++`. If `run+1 == LOCK_CNT`, go to LOCKED.
  - Mismatch: re-seed from this sample (`expected <= in_data + step`, `step_q <= step`, `run <= 1`). Stay in ACQ. No `mismatch` pulse and no `err_count` change.
- **LOCKED**, on an accepted sample:
  - Match: `expected += step_q`, stay in LOCKED.
  - Mismatch: pulse `mismatch`, increment `err_count`, re-seed from this sample with `run <= 1`, go to ACQ.
- `en` low in any state: next state is IDLE. `expected`, `step_q` and both counters hold. `run` clears.
- `sample_count` increments on every accepted sample, in any state.
- Both counters saturate at 2^CNT_W−1 and clear only on `reset`.
- All additions are modulo 2^WIDTH; wrap-around is a legal match (255+3 → 2 at WIDTH=8).
- `step` is only sampled at seed points. Changes to `step` during a run have no effect until the next re-seed.

## Timing
- All outputs are registered. `locked`, `mismatch`, `expected` and the counters reflect a sample on the cycle after it is accepted.
- Lock latency: `locked` rises 1 cycle after the LOCK_CNT-th consistent sample.
- Deviation response: `locked` falls and `mismatch` pulses together, 1 cycle after the bad sample. `mismatch` is high for exactly 1 cycle per bad sample.
- Back-to-back samples are supported every cycle, with no stall or backpressure.
- Reset, including mid-run: next cycle the state is IDLE and every output is 0 (`locked`, `mismatch`, `expected`, `sample_count`, `err_count`); `step_q` and `run` are also 0.
- `reset` has priority over `en` and `in_valid`.
- `en` low in the same cycle as `in_valid`: the sample is dropped and not counted.

## Structure
- Shared package `seq_pkg`:
  - `typedef enum logic [1:0] {IDLE, ACQ, LOCKED} chk_state_t`;
  - `LOCK_CNT_MIN = 2`.
- The state machine, the `expected`/`step_q` datapath and the `run` counter live in `sequence_checker`.
- Sub-module `seq_sat_counter` (parameter `W`; ports `clk`, `reset`, `inc`, `count`). It is instantiated twice, once for `sample_count` and once for `err_count`.
- A parameter assertion checks `LOCK_CNT >= LOCK_CNT_MIN`.

## Test plan
All scenarios use WIDTH=8, LOCK_CNT=4, CNT_W=16, `step`=3 unless noted.
1. Reset, then idle → all outputs 0. `in_valid` with `en`=0 → `sample_count` stays 0.
2. Samples 10, 13, 16, 19 back-to-back → `locked`=1 one cycle after 19, `expected`=22, `sample_count`=4, no `mismatch`.
3. While locked, feed 22 then 50 → one-cycle `mismatch`, `err_count`=1, `locked`=0, `expected`=53. Then feed 53, 56, 59 → relock after 59.
4. Wrap-around: 250, 253, 0, 3 → locked, `expected`=6. In ACQ, feed 7, 9 (mismatch then match? no: 7 re-seeds, 9 mismatches and re-seeds) → `err_count` unchanged, `locked` stays 0.
5. Drop `en` while locked → `locked`=0 next cycle; counters and `expected` hold. Re-enable with 100 → state is ACQ with `expected`=103.
6. CNT_W=2: lock, then force 5 mismatches each followed by relock → `err_count` saturates at 3. Assert `reset` after 2 samples of a run → everything is 0 next cycle.
